// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 fetch/address generator: opcodes,
// controller states and condition-code bit positions.
package lc3_pkg;

  // LC-3 opcode encodings used by the fetch generator
  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_TRAP = 4'hF;

  // Condition-code bit positions within a 3-bit NZP field
  localparam int NZP_N = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_P = 0;

  // Controller states
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC     = 3'd1,
    S_IND_WAIT = 3'd2,
    S_IND_USE  = 3'd3,
    S_DONE     = 3'd4
  } fetch_state_e;

  // True when any requested condition bit matches the current codes
  function automatic logic br_taken(input logic [2:0] br_nzp, input logic [2:0] cc);
    return (br_nzp[NZP_N] & cc[NZP_N]) |
           (br_nzp[NZP_Z] & cc[NZP_Z]) |
           (br_nzp[NZP_P] & cc[NZP_P]);
  endfunction

endpackage

// File: rtl/lc3_sext.sv
// Parametrised sign/zero extender for instruction offset fields.
module lc3_sext #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 16,
  parameter bit ZEXT  = 1'b0
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o
);

  logic fill;
  assign fill = ZEXT ? 1'b0 : in_i[IN_W-1];

  // Widen with the fill bit; equal widths pass straight through
  generate
    if (OUT_W > IN_W) begin : g_ext
      assign out_o = {{(OUT_W-IN_W){fill}}, in_i};
    end else begin : g_pass
      assign out_o = in_i[OUT_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/fetch_gen.sv
// Next-PC and data-memory address generator for every LC-3 opcode class.
// One request is accepted in IDLE; the controller walks EXEC, optionally
// IND_WAIT/IND_USE for memory-indirect forms, then DONE which issues the
// instruction-fetch address and increments the PC.
module fetch_gen
  import lc3_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_start,
  input  logic [3:0]        opCode_in,
  input  logic [10:0]       offset_in,
  input  logic [ADDR_W-1:0] reg_in,
  input  logic [2:0]        br_nzp,
  input  logic [2:0]        result_nzp,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] addr_out,
  output logic              wea_out,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] r7_out,
  output logic              r7_we,
  output logic              busy,
  output logic              fetch_done
);

  fetch_state_e      state_q;
  logic [3:0]        op_q;
  logic [10:0]       off_q;
  logic [ADDR_W-1:0] base_q;
  logic [2:0]        br_nzp_q;
  logic [2:0]        cc_q;

  logic [ADDR_W-1:0] addr_q, pc_q, r7_q;
  logic              wea_q, r7_we_q, busy_q, done_q;

  logic [ADDR_W-1:0] ext9, ext6, ext10, zext8;
  logic [ADDR_W-1:0] ea_pc, ea_base, jsr_tgt, ind_ptr;

  // Offset forms, all taken from the latched instruction bits
  lc3_sext #(.IN_W(9),  .OUT_W(ADDR_W), .ZEXT(1'b0)) u_sext9  (.in_i(off_q[8:0]), .out_o(ext9));
  lc3_sext #(.IN_W(6),  .OUT_W(ADDR_W), .ZEXT(1'b0)) u_sext6  (.in_i(off_q[5:0]), .out_o(ext6));
  lc3_sext #(.IN_W(10), .OUT_W(ADDR_W), .ZEXT(1'b0)) u_sext10 (.in_i(off_q[9:0]), .out_o(ext10));
  lc3_sext #(.IN_W(8),  .OUT_W(ADDR_W), .ZEXT(1'b1)) u_zext8  (.in_i(off_q[7:0]), .out_o(zext8));

  // Address arithmetic wraps modulo 2^ADDR_W
  assign ea_pc   = pc_q + ext9;
  assign ea_base = base_q + ext6;
  // off[10] selects PC-relative JSR; otherwise JSRR through the base register
  assign jsr_tgt = off_q[10] ? (pc_q + ext10) : base_q;
  // Only the low ADDR_W bits of a memory word form a pointer
  assign ind_ptr = mem_rdata[ADDR_W-1:0];

  generate
    if (DATA_W > ADDR_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^mem_rdata[DATA_W-1:ADDR_W];
    end
  endgenerate

  // Controller: state sequencing, input capture and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      off_q    <= '0;
      base_q   <= '0;
      br_nzp_q <= '0;
      cc_q     <= '0;
      addr_q   <= '0;
      pc_q     <= RESET_PC;
      r7_q     <= '0;
      wea_q    <= 1'b0;
      r7_we_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below
      wea_q   <= 1'b0;
      r7_we_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fetch_start) begin
            op_q     <= opCode_in;
            off_q    <= offset_in;
            base_q   <= reg_in;
            br_nzp_q <= br_nzp;
            cc_q     <= result_nzp;
            busy_q   <= 1'b1;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          state_q <= S_DONE;
          case (op_q)
            OP_LD, OP_ST: begin
              addr_q <= ea_pc;
              wea_q  <= (op_q == OP_ST);
            end
            OP_LDR, OP_STR: begin
              addr_q <= ea_base;
              wea_q  <= (op_q == OP_STR);
            end
            OP_LDI, OP_STI: begin
              // First access reads the pointer, never writes
              addr_q  <= ea_pc;
              state_q <= S_IND_WAIT;
            end
            OP_TRAP: begin
              addr_q  <= zext8;
              r7_q    <= pc_q;
              r7_we_q <= 1'b1;
              state_q <= S_IND_WAIT;
            end
            OP_BR: begin
              if (br_taken(br_nzp_q, cc_q)) pc_q <= ea_pc;
            end
            OP_JMP: begin
              pc_q <= base_q;
            end
            OP_JSR: begin
              // Link captures the old PC even when JSRR targets the same value
              r7_q    <= pc_q;
              r7_we_q <= 1'b1;
              pc_q    <= jsr_tgt;
            end
            default: ;
          endcase
        end
        S_IND_WAIT: begin
          // Memory returns the pointer word during the next cycle
          state_q <= S_IND_USE;
        end
        S_IND_USE: begin
          if (op_q == OP_TRAP) begin
            pc_q <= ind_ptr;
          end else begin
            addr_q <= ind_ptr;
            wea_q  <= (op_q == OP_STI);
          end
          state_q <= S_DONE;
        end
        S_DONE: begin
          addr_q  <= pc_q;
          pc_q    <= pc_q + ADDR_W'(1);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign addr_out   = addr_q;
  assign wea_out    = wea_q;
  assign pc         = pc_q;
  assign r7_out     = r7_q;
  assign r7_we      = r7_we_q;
  assign busy       = busy_q;
  assign fetch_done = done_q;

endmodule

// File: tb/tb_fetch_gen.sv
// Self-checking bench for fetch_gen: directed scenarios plus randomized
// transactions checked cycle by cycle against an instruction-level model.
module tb_fetch_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_start;
  logic [3:0]  opCode_in;
  logic [10:0] offset_in;
  logic [15:0] reg_in;
  logic [2:0]  br_nzp, result_nzp;
  logic [15:0] mem_rdata;
  logic [15:0] addr_out, pc, r7_out;
  logic        wea_out, r7_we, busy, fetch_done;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Model state: architectural PC, last driven address, link register
  logic [15:0] m_pc, m_addr, m_r7;
  logic [15:0] ovr_a, ovr_d;

  fetch_gen #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start),
    .opCode_in(opCode_in), .offset_in(offset_in), .reg_in(reg_in),
    .br_nzp(br_nzp), .result_nzp(result_nzp), .mem_rdata(mem_rdata),
    .addr_out(addr_out), .wea_out(wea_out), .pc(pc), .r7_out(r7_out),
    .r7_we(r7_we), .busy(busy), .fetch_done(fetch_done)
  );

  always #5 clk = ~clk;

  // Memory contents: one overridable word, otherwise a fixed scramble
  function automatic logic [15:0] memf(input logic [15:0] a);
    if (a == ovr_a) return ovr_d;
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Synchronous read memory: data valid one cycle after its address
  always @(posedge clk) mem_rdata <= memf(addr_out);

  task automatic model_reset();
    m_pc = 16'h0000; m_addr = 16'h0000; m_r7 = 16'h0000;
  endtask

  // Issue one transaction starting #1 after an edge with the DUT idle,
  // check every cycle through fetch_done, then final pc / r7_out.
  task automatic run_txn(input logic [3:0] op, input logic [10:0] off,
                         input logic [15:0] rg, input logic [2:0] bn,
                         input logic [2:0] rn, input bit hold, input string nm);
    logic [15:0] a_e [0:4];
    bit          w_e [0:4];
    bit          l_e [0:4];
    int          e9, e6, e10, n;
    logic [15:0] ea, npc, tv;
    bit          link;
    logic [19:0] obs, ex;
    e9 = int'(off[8:0]); if (e9 >= 256) e9 -= 512;
    e6 = int'(off[5:0]); if (e6 >= 32) e6 -= 64;
    e10 = int'(off[9:0]); if (e10 >= 512) e10 -= 1024;
    n = 2; npc = m_pc; link = 0;
    for (int k = 0; k < 5; k++) begin a_e[k] = m_addr; w_e[k] = 0; l_e[k] = 0; end
    case (op)
      4'h0: if ((bn & rn) != 3'b000) npc = 16'(int'(m_pc) + e9);
      4'h2, 4'h3: begin ea = 16'(int'(m_pc) + e9); a_e[1] = ea; w_e[1] = (op == 4'h3); end
      4'h6, 4'h7: begin ea = 16'(int'(rg) + e6); a_e[1] = ea; w_e[1] = (op == 4'h7); end
      4'hA, 4'hB: begin
        ea = 16'(int'(m_pc) + e9); n = 4;
        a_e[1] = ea; a_e[2] = ea; a_e[3] = memf(ea); w_e[3] = (op == 4'hB);
      end
      4'hF: begin
        tv = {8'h00, off[7:0]}; n = 4; link = 1;
        a_e[1] = tv; a_e[2] = tv; a_e[3] = tv; npc = memf(tv);
      end
      4'hC: npc = rg;
      4'h4: begin link = 1; npc = off[10] ? 16'(int'(m_pc) + e10) : rg; end
      default: ;
    endcase
    if (link) begin l_e[1] = 1; m_r7 = m_pc; end
    a_e[n] = npc;

    opCode_in = op; offset_in = off; reg_in = rg; br_nzp = bn; result_nzp = rn;
    fetch_start = 1'b1;
    for (int k = 0; k <= n; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        fetch_start = hold;
        if (hold) begin
          opCode_in = 4'($urandom); offset_in = 11'($urandom); reg_in = 16'($urandom);
          br_nzp = 3'($urandom); result_nzp = 3'($urandom);
        end
      end
      obs = {addr_out, wea_out, r7_we, fetch_done, busy};
      ex  = {a_e[k], w_e[k], l_e[k], (k == n), (k != n)};
      tot_cnt++;
      if (obs !== ex) $display("FAIL %s cyc%0d {addr,wea,r7we,done,busy}: got %h/%b%b%b%b want %h/%b%b%b%b",
                               nm, k, obs[19:4], obs[3], obs[2], obs[1], obs[0],
                               ex[19:4], ex[3], ex[2], ex[1], ex[0]);
      else pass_cnt++;
    end
    fetch_start = 1'b0;
    m_pc = npc + 16'd1; m_addr = a_e[n];
    tot_cnt++;
    if (pc !== m_pc || r7_out !== m_r7)
      $display("FAIL %s pc/r7: got %h/%h want %h/%h", nm, pc, r7_out, m_pc, m_r7);
    else pass_cnt++;
  endtask

  task automatic set_pc(input logic [15:0] target);
    run_txn(4'hC, 11'h000, target - 16'd1, 3'b000, 3'b000, 1'b0, "jmp_setpc");
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_start = 1'b0; opCode_in = 4'h7; offset_in = 11'h03F;
    reg_in = 16'h4000; br_nzp = 3'b000; result_nzp = 3'b000;
    ovr_a = 16'hFFFF; ovr_d = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tot_cnt++;
    if ({addr_out, wea_out, pc, busy, fetch_done, r7_we, r7_out} !== {16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0})
      $display("FAIL reset_idle: addr=%h wea=%b pc=%h busy=%b done=%b r7we=%b r7=%h want all zero",
               addr_out, wea_out, pc, busy, fetch_done, r7_we, r7_out);
    else pass_cnt++;
  endtask

  task automatic test_str();
    set_pc(16'h0010);
    run_txn(4'h7, 11'h03F, 16'h4000, 3'b000, 3'b000, 1'b0, "str");
    tot_cnt++;
    if (pc !== 16'h0011 || addr_out !== 16'h0010)
      $display("FAIL str_final: pc=%h addr=%h want 0011/0010", pc, addr_out);
    else pass_cnt++;
  endtask

  task automatic test_br();
    set_pc(16'h0020);
    run_txn(4'h0, 11'h1FE, 16'h0000, 3'b010, 3'b010, 1'b0, "br_taken");
    tot_cnt++;
    if (pc !== 16'h001F) $display("FAIL br_taken_pc: got %h want 001f", pc);
    else pass_cnt++;
    set_pc(16'h0020);
    run_txn(4'h0, 11'h1FE, 16'h0000, 3'b010, 3'b100, 1'b0, "br_not_taken");
    tot_cnt++;
    if (pc !== 16'h0021) $display("FAIL br_not_taken_pc: got %h want 0021", pc);
    else pass_cnt++;
  endtask

  task automatic test_ldi();
    set_pc(16'h0030);
    ovr_a = 16'h0035; ovr_d = 16'h8000;
    run_txn(4'hA, 11'h005, 16'h0000, 3'b000, 3'b000, 1'b0, "ldi");
    tot_cnt++;
    if (pc !== 16'h0031 || addr_out !== 16'h0030)
      $display("FAIL ldi_final: pc=%h addr=%h want 0031/0030", pc, addr_out);
    else pass_cnt++;
  endtask

  task automatic test_trap_reset();
    set_pc(16'h3001);
    ovr_a = 16'h0025; ovr_d = 16'hFD70;
    run_txn(4'hF, 11'h025, 16'h0000, 3'b000, 3'b000, 1'b0, "trap");
    tot_cnt++;
    if (pc !== 16'hFD71 || r7_out !== 16'h3001)
      $display("FAIL trap_final: pc=%h r7=%h want fd71/3001", pc, r7_out);
    else pass_cnt++;
    // Second trap, interrupted by reset while in IND_WAIT
    opCode_in = 4'hF; offset_in = 11'h025; fetch_start = 1'b1;
    @(posedge clk); #1; fetch_start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    tot_cnt++;
    if ({addr_out, wea_out, pc, busy, fetch_done, r7_we, r7_out} !== {16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0})
      $display("FAIL trap_mid_reset: addr=%h wea=%b pc=%h busy=%b done=%b r7we=%b r7=%h want all zero",
               addr_out, wea_out, pc, busy, fetch_done, r7_we, r7_out);
    else pass_cnt++;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    set_pc(16'hFFFF);
    run_txn(4'hE, 11'h123, 16'h1234, 3'b111, 3'b111, 1'b0, "wrap_other");
    tot_cnt++;
    if (pc !== 16'h0000 || addr_out !== 16'hFFFF)
      $display("FAIL wrap_final: pc=%h addr=%h want 0000/ffff", pc, addr_out);
    else pass_cnt++;
  endtask

  task automatic test_jsrr_same();
    set_pc(16'h0100);
    run_txn(4'h4, 11'h000, 16'h0100, 3'b000, 3'b000, 1'b0, "jsrr_same");
    tot_cnt++;
    if (r7_out !== 16'h0100 || pc !== 16'h0101)
      $display("FAIL jsrr_same_final: r7=%h pc=%h want 0100/0101", r7_out, pc);
    else pass_cnt++;
  endtask

  // Random opcodes with fetch_start held and inputs scrambled while busy
  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      run_txn(4'($urandom), 11'($urandom), 16'($urandom), 3'($urandom),
              3'($urandom), 1'($urandom_range(0, 1)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_str();
    test_br();
    test_ldi();
    test_trap_reset();
    test_wrap();
    test_jsrr_same();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_gen.md
# fetch_gen

Parametrised successor to the LC-3 `fetch` block. It computes the next PC and the data-memory address / write-enable for every LC-3 opcode class. Beyond the original it covers:
- indirect loads and stores (LDI/STI) through a two-access sequence;
- subroutine and trap control flow (JSR/JSRR/JMP/TRAP) with a R7 link write;
- an explicit start/done handshake.

It sits between decode (opcode, offset, base register, NZP) and the single-port unified memory.

## Interface
Parameters:
- `ADDR_W`, 16, address and PC width.
- `DATA_W`, 16, memory word width; must be ≥ `ADDR_W`.
- `RESET_PC`, 0, PC value after reset.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_start`  in  1  one-cycle request; sampled only in IDLE.
- `opCode_in`  in  4  LC-3 opcode.
- `offset_in`  in  11  instruction bits [10:0].
- `reg_in`  in  `ADDR_W`  BaseR value (JMP/JSRR/LDR/STR).
- `br_nzp`  in  3  BR condition bits.
- `result_nzp`  in  3  current condition codes.
- `mem_rdata`  in  `DATA_W`  memory read data; valid one cycle after its address is driven.
- `addr_out`  out  `ADDR_W`  memory address.
- `wea_out`  out  1  memory write enable.
- `pc`  out  `ADDR_W`  program counter.
- `r7_out`  out  `ADDR_W`  link value.
- `r7_we`  out  1  one-cycle R7 write strobe.
- `busy`  out  1  high whenever state ≠ IDLE.
- `fetch_done`  out  1  one-cycle completion pulse.

## Operation
- All inputs are latched on the edge that accepts `fetch_start`. `fetch_start` is ignored outside IDLE; there is no queueing.
- Offset extension, selected by latched opcode:
  - SEXT(off[8:0]): BR, LD, ST, LDI, STI.
  - SEXT(off[5:0]): LDR, STR.
  - SEXT(off[10:0]): JSR, but only when off[11] is unavailable; JSR vs JSRR is selected by off[10]=1 for JSR, using SEXT(off[9:0]).
  - ZEXT(off[7:0]): TRAP.
- Arithmetic is modulo 2^`ADDR_W`; wrap-around is silent.
- Effective address (EA):
  - PC-relative (LD/ST/LDI/STI): `pc` + ext.
  - Base-relative (LDR/STR): `reg_in` + ext.
- States:
  - IDLE → EXEC on `fetch_start`.
  - EXEC, by opcode:
    - LD/LDR/ST/STR: `addr_out`=EA, `wea_out`=1 for ST/STR; → DONE.
    - LDI/STI: `addr_out`=EA, `wea_out`=0; → IND_WAIT.
    - TRAP: `addr_out`=ZEXT(trapvect8), `r7_out`=`pc`, `r7_we`=1; → IND_WAIT.
    - BR: taken iff |(`br_nzp` & `result_nzp`); if taken, `pc`=`pc`+ext. → DONE.
    - JMP: `pc`=`reg_in`; → DONE.
    - JSR/JSRR: `r7_out`=`pc`, `r7_we`=1; `pc`=`pc`+ext (JSR) or `reg_in` (JSRR); → DONE.
    - All other opcodes: → DONE.
  - IND_WAIT: `wea_out`=0; → IND_USE.
  - IND_USE: LDI/STI: `addr_out`=`mem_rdata`[`ADDR_W`-1:0], `wea_out`=1 for STI; TRAP: `pc`=`mem_rdata`[`ADDR_W`-1:0]. → DONE.
  - DONE: `addr_out`=`pc` (instruction fetch), `wea_out`=0, `pc`=`pc`+1, `fetch_done`=1; → IDLE.
- JSRR where `reg_in` equals the old PC: R7 receives the old PC and `pc` equals `reg_in`. No hazard.

## Timing
- All outputs are registered.
- Reset values: `addr_out`=0, `wea_out`=0, `pc`=`RESET_PC`, `r7_out`=0, `r7_we`=0, `busy`=0, `fetch_done`=0, state IDLE.
- Latency from the accepting edge to `fetch_done`:
  - 2 cycles for direct accesses, BR, JMP, JSR and others.
  - 4 cycles for LDI/STI/TRAP.
- `wea_out` is high for exactly one cycle per ST/STR/STI and never in the same cycle as an instruction-fetch address.
- `r7_we` pulses for one cycle, in the EXEC output cycle.
- `rst_n` asserted mid-transaction returns every output to its reset value immediately. The transaction is discarded; there is no partial write beyond any already-asserted cycle.
- `fetch_start` held high: a new transaction is accepted on the first edge in IDLE after `fetch_done`. Back-to-back throughput is one transaction per 3 cycles (direct) or 5 cycles (indirect).

## Structure
- Package `lc3_pkg`: opcode localparams (BR, LD, ST, JSR, LDR, STR, JMP, LDI, STI, TRAP), the state enum, and the NZP bit positions.
- Sub-module `lc3_sext`: a parametrised sign/zero extender (input width, output width, zero-extend flag), instantiated once per offset form.

## Test plan
- Reset only, STR opcode applied, `fetch_start`=0 for 5 cycles → `addr_out`=0, `wea_out`=0, `pc`=0, `busy`=0.
- `pc`=0x0010, STR with `reg_in`=0x4000, offset6=0x3F → one cycle of `addr_out`=0x3FFF with `wea_out`=1. Then `addr_out`=0x0010, `pc`=0x0011, `fetch_done` pulse.
- BR with `br_nzp`=010: once with `result_nzp`=010 and offset9=0x1FE, once with `result_nzp`=100. From `pc`=0x0020 → `pc`=0x001F when taken, 0x0021 when not taken.
- LDI at `pc`=0x0030, offset9=5, `mem_rdata`=0x8000 on the cycle after EA=0x0035 → `addr_out` sequence 0x0035, 0x8000, 0x0030; `wea_out`=0 throughout; done after 4 cycles.
- TRAP x25 at `pc`=0x3001, `mem_rdata`=0xFD70 → `r7_out`=0x3001 with a one-cycle `r7_we`; final `pc`=0xFD71. Pulse `rst_n` low during IND_WAIT → all outputs return to reset values.
- `pc`=0xFFFF, opcode 0xE (other class) → `addr_out`=0xFFFF, `pc` wraps to 0x0000.
